lpc_periph_mw: RTL
==================

LPC_PERIPH_MW -- requirements
Module: lpc_periph_mw

Interface
REQ-001 SHALL have parameter NUM_WIN, default 4 (1..8): number of decode windows.
REQ-002 SHALL have parameter WIN_BASE, default 0x0000_0080 replicated, NUM_WIN*32 bits: per-window base address, window k in bits [32k+31:32k].
REQ-003 SHALL have parameter WIN_MASK, default 0xFFFF_FFF0 replicated, NUM_WIN*32 bits: per-window compare mask; a 1 bit is compared.
REQ-004 SHALL have parameter WIN_MEM, default all 0, NUM_WIN bits: per window, 1 = memory cycles, 0 = I/O cycles.
REQ-005 SHALL have parameter MAX_WAIT, default 64: long-wait SYNC limit in clocks.
REQ-006 SHALL have port clk_i, input, 1: LPC clock; all logic on the rising edge.
REQ-007 SHALL have port nrst_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port lframe_i, input, 1: active-low LPC frame.
REQ-009 SHALL have port lad_bus, inout, 4: LPC LAD.
REQ-010 SHALL have port req_o, output, 1: backend request.
REQ-011 SHALL have port we_o, output, 1: 1 = write.
REQ-012 SHALL have port addr_o, output, 32: cycle address, zero-extended for I/O.
REQ-013 SHALL have port wdata_o, output, 8: write data.
REQ-014 SHALL have port win_o, output, 3: index of the hit window.
REQ-015 SHALL have port ack_i, input, 1: backend done.
REQ-016 SHALL have port rdata_i, input, 8: read data, valid with ack_i.
REQ-017 SHALL have port err_i, input, 1: backend error, valid with ack_i.
REQ-018 SHALL have port busy_o, output, 1: high outside IDLE.
REQ-019 SHALL have port current_state_o, output, 5: state encoding.

Function
REQ-020 The FSM SHALL be IDLE, CYCTYPE, ADDR, WDATA, HTAR1, HTAR2, SYNC, RDATA, PTAR1, PTAR2; each LAD nibble occupies one clock.
REQ-021 START SHALL be lframe_i=0 with LAD=0000; FSM enters CYCTYPE; with lframe_i held low, the last such clock counts.
REQ-022 In CYCTYPE, LAD[3:2]=00 SHALL mean I/O (4 address nibbles) and 01 memory (8 nibbles); LAD[1]=1 means write; other types return the FSM to IDLE.
REQ-023 The address SHALL shift in MSB nibble first; write data SHALL shift in low nibble first.
REQ-024 Decode SHALL occur on the clock after the last address nibble: hit = (addr & MASK) == (BASE & MASK) with matching WIN_MEM; the lowest index wins.
REQ-025 On a miss, the FSM SHALL return to IDLE and lad_bus SHALL never be driven.
REQ-026 After HTAR1/HTAR2 (host-driven, ignored), the FSM SHALL enter SYNC and assert req_o with addr_o/we_o/wdata_o/win_o stable until the clock after ack_i.
REQ-027 In SYNC, LAD SHALL be 0110 (long wait) each clock ack_i is low; on the clock after ack_i: 0000 (ready), or 1010 (error) if err_i.
REQ-028 If MAX_WAIT clocks pass without ack_i, the block SHALL drive 1010, drop req_o and skip RDATA; a late ack_i SHALL be ignored.
REQ-029 A read SHALL drive rdata_i captured at ack, low nibble then high, in RDATA (2 clocks); error SYNC SHALL skip RDATA.
REQ-030 In PTAR1 LAD SHALL be 1111; in PTAR2 LAD SHALL be released; the FSM then returns to IDLE.
REQ-031 lad_bus drive value and enable SHALL be registered; no combinational path from lad_bus to lad_bus.
REQ-032 lframe_i low in any non-IDLE state SHALL abort: LAD released and req_o dropped on the next clock; it is a new START if LAD=0000, otherwise IDLE.
REQ-033 ack_i in the same clock as req_o rises SHALL be accepted (minimum one long-wait clock).

Reset
REQ-034 nrst_i low SHALL asynchronously force IDLE, release lad_bus, and zero req_o, we_o, addr_o, wdata_o, win_o, busy_o, current_state_o and the wait counter.
REQ-035 Reset mid-cycle SHALL discard the cycle without any backend handshake.

Structure
REQ-036 Package lpc_pkg SHALL hold the state encoding, cycle-type codes and SYNC codes (0000, 0110, 1010).
REQ-037 Window matching SHALL be a sub-module lpc_addr_decode (address, is_mem in; hit, index out; combinational).

Verification
REQ-038 I/O write 0x0084 ← 0x5A, window 0 base 0x80: req_o with addr_o=0x84, wdata_o=0x5A, win_o=0; SYNC 0110 then 0000.
REQ-039 I/O read 0x0081, ack after 3 clocks with rdata_i=0xA5: 3× 0110, 0000, LAD 5 then A, 1111, float.
REQ-040 Memory read 0xFED4_0000 hitting window 2 (WIN_MEM[2]=1): win_o=2, 8 address nibbles accepted.
REQ-041 I/O read 0x0300 (no hit): lad_bus stays Z, req_o stays 0.
REQ-042 No ack with MAX_WAIT=4: 4× 0110, then 1010, req_o low; a subsequent ack is ignored.
REQ-043 lframe_i low during SYNC: req_o drops next clock, LAD released; a following START and cycle completes normally.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared encodings for the LPC peripheral: FSM states, cycle-type codes
// and the LAD nibbles the peripheral drives.
package lpc_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'd0,
        ST_CYCTYPE = 5'd1,
        ST_ADDR    = 5'd2,
        ST_WDATA   = 5'd3,
        ST_HTAR1   = 5'd4,
        ST_HTAR2   = 5'd5,
        ST_SYNC    = 5'd6,
        ST_RDATA   = 5'd7,
        ST_PTAR1   = 5'd8,
        ST_PTAR2   = 5'd9
    } lpc_state_e;

    localparam logic [3:0] LAD_START  = 4'b0000;
    localparam logic [3:0] LAD_TAR    = 4'b1111;

    localparam logic [1:0] CT_IO      = 2'b00;
    localparam logic [1:0] CT_MEM     = 2'b01;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

endpackage

// File: rtl/lpc_addr_decode.sv
// Combinational window match: masked base compare plus cycle-kind match,
// lowest matching window index wins.
module lpc_addr_decode #(
    parameter int                    NUM_WIN  = 4,
    parameter logic [NUM_WIN*32-1:0] WIN_BASE = {NUM_WIN{32'h0000_0080}},
    parameter logic [NUM_WIN*32-1:0] WIN_MASK = {NUM_WIN{32'hFFFF_FFF0}},
    parameter logic [NUM_WIN-1:0]    WIN_MEM  = '0
) (
    input  logic [31:0] addr,
    input  logic        is_mem,
    output logic        hit,
    output logic [2:0]  index
);

    // Walk from the top down so the lowest matching index is the last write.
    always_comb begin
        hit   = 1'b0;
        index = 3'd0;
        for (int k = NUM_WIN - 1; k >= 0; k--) begin
            if (((addr & WIN_MASK[32*k +: 32]) == (WIN_BASE[32*k +: 32] & WIN_MASK[32*k +: 32]))
                && (WIN_MEM[k] == is_mem)) begin
                hit   = 1'b1;
                index = 3'(k);
            end
        end
    end

endmodule

// File: rtl/lpc_periph_mw.sv
// LPC peripheral target for I/O and memory single-byte cycles with a simple
// req/ack backend. LAD drive value and enable are registered.
module lpc_periph_mw
    import lpc_pkg::*;
#(
    parameter int                    NUM_WIN  = 4,
    parameter logic [NUM_WIN*32-1:0] WIN_BASE = {NUM_WIN{32'h0000_0080}},
    parameter logic [NUM_WIN*32-1:0] WIN_MASK = {NUM_WIN{32'hFFFF_FFF0}},
    parameter logic [NUM_WIN-1:0]    WIN_MEM  = '0,
    parameter int                    MAX_WAIT = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    inout  wire  [3:0]  lad_bus,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [7:0]  wdata_o,
    output logic [2:0]  win_o,
    input  logic        ack_i,
    input  logic [7:0]  rdata_i,
    input  logic        err_i,
    output logic        busy_o,
    output logic [4:0]  current_state_o
);

    localparam int WCW = $clog2(MAX_WAIT) + 1;

    lpc_state_e     state, next_state;
    logic [3:0]     lad_in, lad_q, lad_d;
    logic           lad_oe, oe_d, req_d;
    logic           is_mem, sync_last, err_q, hit;
    logic [2:0]     nib_cnt, hit_idx;
    logic [7:0]     rdata_q;
    logic [WCW-1:0] wait_cnt;
    logic           abort, addr_last, decode_clk, sync_wait, acked, timeout;

    assign lad_in  = lad_bus;
    assign lad_bus = lad_oe ? lad_q : 4'bzzzz;

    assign abort      = (state != ST_IDLE) && !lframe_i;
    assign addr_last  = (nib_cnt == (is_mem ? 3'd7 : 3'd3));
    // Full address is registered; decode in the clock that follows it.
    assign decode_clk = ((state == ST_WDATA) && (nib_cnt == 3'd0)) || ((state == ST_HTAR1) && !we_o);
    assign sync_wait  = (state == ST_SYNC) && !sync_last;
    assign acked      = sync_wait && ack_i;
    assign timeout    = sync_wait && !ack_i && (wait_cnt == WCW'(MAX_WAIT - 1));

    assign busy_o          = (state != ST_IDLE);
    assign current_state_o = state;

    lpc_addr_decode #(
        .NUM_WIN  (NUM_WIN),
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (WIN_MASK),
        .WIN_MEM  (WIN_MEM)
    ) u_decode (
        .addr   (addr_o),
        .is_mem (is_mem),
        .hit    (hit),
        .index  (hit_idx)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = (lad_in == LAD_START) ? ST_CYCTYPE : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (!lframe_i && (lad_in == LAD_START)) next_state = ST_CYCTYPE;
                ST_CYCTYPE: next_state = ((lad_in[3:2] == CT_IO) || (lad_in[3:2] == CT_MEM)) ? ST_ADDR : ST_IDLE;
                ST_ADDR:    if (addr_last) next_state = we_o ? ST_WDATA : ST_HTAR1;
                ST_WDATA: begin
                    if (decode_clk && !hit)     next_state = ST_IDLE;
                    else if (nib_cnt == 3'd1)   next_state = ST_HTAR1;
                end
                ST_HTAR1:   next_state = (decode_clk && !hit) ? ST_IDLE : ST_HTAR2;
                ST_HTAR2:   next_state = ST_SYNC;
                ST_SYNC:    if (sync_last) next_state = (!we_o && !err_q) ? ST_RDATA : ST_PTAR1;
                ST_RDATA:   if (nib_cnt == 3'd1) next_state = ST_PTAR1;
                ST_PTAR1:   next_state = ST_PTAR2;
                ST_PTAR2:   next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Values for the registered LAD driver and req_o, keyed on where the FSM goes next.
    always_comb begin
        oe_d  = 1'b0;
        lad_d = LAD_TAR;
        req_d = 1'b0;
        case (next_state)
            ST_SYNC: begin
                oe_d = 1'b1;
                if (acked)        lad_d = err_i ? SYNC_ERR : SYNC_READY;
                else if (timeout) lad_d = SYNC_ERR;
                else begin
                    lad_d = SYNC_LWAIT;
                    req_d = 1'b1;
                end
            end
            ST_RDATA: begin
                oe_d  = 1'b1;
                lad_d = (state == ST_RDATA) ? rdata_q[7:4] : rdata_q[3:0];
            end
            ST_PTAR1: begin
                oe_d  = 1'b1;
                lad_d = LAD_TAR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            lad_oe    <= 1'b0;
            lad_q     <= '0;
            req_o     <= 1'b0;
            we_o      <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            win_o     <= '0;
            is_mem    <= 1'b0;
            nib_cnt   <= '0;
            wait_cnt  <= '0;
            sync_last <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            lad_oe <= oe_d;
            lad_q  <= lad_d;
            req_o  <= req_d;
            case (state)
                ST_CYCTYPE: begin
                    we_o    <= lad_in[1];
                    is_mem  <= (lad_in[3:2] == CT_MEM);
                    addr_o  <= '0;
                    nib_cnt <= '0;
                end
                ST_ADDR: begin
                    addr_o  <= {addr_o[27:0], lad_in};
                    nib_cnt <= addr_last ? 3'd0 : nib_cnt + 3'd1;
                end
                ST_WDATA: begin
                    if (nib_cnt == 3'd0) wdata_o[3:0] <= lad_in;
                    else                 wdata_o[7:4] <= lad_in;
                    nib_cnt <= nib_cnt + 3'd1;
                end
                ST_HTAR2: begin
                    wait_cnt  <= '0;
                    sync_last <= 1'b0;
                    err_q     <= 1'b0;
                end
                ST_SYNC: begin
                    if (sync_wait) begin
                        if (ack_i) begin
                            sync_last <= 1'b1;
                            err_q     <= err_i;
                            rdata_q   <= rdata_i;
                        end else if (timeout) begin
                            sync_last <= 1'b1;
                            err_q     <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WCW'(1);
                        end
                    end else begin
                        nib_cnt <= '0;
                    end
                end
                ST_RDATA: nib_cnt <= nib_cnt + 3'd1;
                default: ;
            endcase
            if (decode_clk && hit) win_o <= hit_idx;
        end
    end

endmodule
